// File: rtl/idiot_pkg.sv
// Shared definitions for the IDIOT core: word/address widths and the
// reset values of the read-only constant registers.
package idiot_pkg;

  localparam int unsigned WORD_W         = 16;
  localparam int unsigned REGADDR_W      = 6;
  localparam int unsigned NCONST_DEFAULT = 4;

  localparam logic [15:0] CONST_R0 = 16'h0000;
  localparam logic [15:0] CONST_R1 = 16'h0001;
  localparam logic [15:0] CONST_R2 = 16'h8000;
  localparam logic [15:0] CONST_R3 = 16'hFFFF;

  function automatic logic [15:0] const_reset(input int unsigned idx);
    logic [15:0] val;
    case (idx)
      0:       val = CONST_R0;
      1:       val = CONST_R1;
      2:       val = CONST_R2;
      3:       val = CONST_R3;
      default: val = 16'h0000;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on
// writeback, plus a population count of the set bits.
module reg_scoreboard #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned NCONST = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_dst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  output logic [DEPTH-1:0] pending,
  output logic [CW-1:0]    pend_cnt
);

  logic [DEPTH-1:0] pending_q, pending_d;

  always_comb begin
    pending_d = pending_q;
    if (wr_en) begin
      pending_d[wr_addr] = 1'b0;
    end
    // Applied after the clear so a newer producer on the same edge wins.
    if (iss_valid && (32'(iss_dst) >= NCONST)) begin
      pending_d[iss_dst] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      pend_cnt = pend_cnt + CW'(pending_q[i]);
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with NREAD registered read ports, one bypassed write port,
// read-only constant registers and a combinational issue-hazard stall.
module regfile_scoreboard
  import idiot_pkg::*;
#(
  parameter int unsigned WIDTH  = WORD_W,
  parameter int unsigned DEPTH  = 2 ** REGADDR_W,
  parameter int unsigned NREAD  = 2,
  parameter int unsigned NCONST = NCONST_DEFAULT,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*WIDTH-1:0] rd_data,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   iss_valid,
  input  logic [AW-1:0]          iss_dst,
  output logic                   stall,
  output logic [CW-1:0]          pend_cnt
);

  logic [WIDTH-1:0]       regs_q [DEPTH];
  logic [WIDTH-1:0]       regs_d [DEPTH];
  logic [NREAD*WIDTH-1:0] rd_data_q, rd_data_d;
  logic [AW-1:0]          rd_a [NREAD];
  logic [DEPTH-1:0]       pending;
  logic                   wr_ok;

  assign wr_ok = wr_en && (32'(wr_addr) >= NCONST);

  always_comb begin
    for (int i = 0; i < int'(NREAD); i++) begin
      rd_a[i] = rd_addr[i*AW +: AW];
    end
  end

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_ok) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= (i < 4) ? WIDTH'(const_reset(i)) : '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Write-through: a read on the same edge as a write sees the new value.
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < int'(NREAD); i++) begin
      if (wr_ok && (wr_addr == rd_a[i])) begin
        rd_data_d[i*WIDTH +: WIDTH] = wr_data;
      end else begin
        rd_data_d[i*WIDTH +: WIDTH] = regs_q[rd_a[i]];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

  reg_scoreboard #(
    .DEPTH  (DEPTH),
    .NCONST (NCONST)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .iss_valid (iss_valid),
    .iss_dst   (iss_dst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .pending   (pending),
    .pend_cnt  (pend_cnt)
  );

  // A register being written back this cycle is covered by the bypass.
  always_comb begin
    stall = 1'b0;
    for (int i = 0; i < int'(NREAD); i++) begin
      if (pending[rd_a[i]] && !(wr_en && (wr_addr == rd_a[i]))) begin
        stall = 1'b1;
      end
    end
  end

endmodule
